// File: rtl/mmio_controller_if.sv
// ---------------------------------------------------------------------------
// mmio_controller_if
// Purpose : Single-port memory-mapped bus between the CPU memory stage and
//           the MMIO controller. The master drives one request per cycle and
//           gets registered read data back one cycle later.
// Signals :
//   addr   - byte address from the memory stage
//   wr_en  - write strobe
//   rd_en  - read strobe
//   wdata  - write data
//   hit    - combinational: addr matches a mapped register
//   rdata  - registered read data
//   rvalid - one-cycle pulse following an accepted read
// ---------------------------------------------------------------------------
interface mmio_controller_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic             wr_en;
    logic             rd_en;
    logic [DBITS-1:0] wdata;
    logic             hit;
    logic [DBITS-1:0] rdata;
    logic             rvalid;

    modport master (
        output addr, wr_en, rd_en, wdata,
        input  hit, rdata, rvalid
    );

    modport slave (
        input  addr, wr_en, rd_en, wdata,
        output hit, rdata, rvalid
    );
endinterface

// File: rtl/mmio_controller.sv
// ---------------------------------------------------------------------------
// mmio_controller
// Purpose : Memory-mapped I/O block for the CPU data path. Owns the HEX,
//           LEDR and LEDG output registers, samples KEY/SW through two-flop
//           synchronisers and per-bit debouncers, and keeps sticky
//           ready/overrun status for both input groups.
// Ports   :
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   bus    - mmio_controller_if.slave (addr, wr_en, rd_en, wdata, hit,
//            rdata, rvalid)
//   key_n  - raw keys, 0 = pressed
//   sw     - raw switches
//   ledr   - red LEDs
//   ledg   - green LEDs
//   hex    - 7-segment digits, active-low, digit 0 in bits [6:0]
// Options : define MMIO_TIMER_EN to add a free-running cycle counter at
//           ADDR_TCNT; without it that address is unmapped.
// ---------------------------------------------------------------------------
module mmio_controller #(
    parameter int               DBITS           = 32,
    parameter int               KEY_BITS        = 4,
    parameter int               SW_BITS         = 10,
    parameter int               LEDR_BITS       = 10,
    parameter int               LEDG_BITS       = 8,
    parameter int               HEX_DIGITS      = 4,
    parameter int               DEBOUNCE_CYCLES = 100000,
    parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF000_0000,
    parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF000_0004,
    parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF000_0008,
    parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF000_0010,
    parameter logic [DBITS-1:0] ADDR_SW         = 32'hF000_0014,
    parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF000_0110,
    parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF000_0114,
    parameter logic [DBITS-1:0] ADDR_TCNT       = 32'hF000_0020
) (
    input  logic                    clk,
    input  logic                    reset,
    mmio_controller_if.slave        bus,
    input  logic [KEY_BITS-1:0]     key_n,
    input  logic [SW_BITS-1:0]      sw,
    output logic [LEDR_BITS-1:0]    ledr,
    output logic [LEDG_BITS-1:0]    ledg,
    output logic [7*HEX_DIGITS-1:0] hex
);

    localparam int HEX_BITS = 4 * HEX_DIGITS;
    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // A counter sitting at CNT_MAX while the input still differs completes
    // the DEBOUNCE_CYCLES-th stable sample on this edge.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Address decode
    logic w_selHex, w_selLedr, w_selLedg, w_selKey, w_selSw;
    logic w_selKctrl, w_selSctrl;

    assign w_selHex   = (bus.addr == ADDR_HEX);
    assign w_selLedr  = (bus.addr == ADDR_LEDR);
    assign w_selLedg  = (bus.addr == ADDR_LEDG);
    assign w_selKey   = (bus.addr == ADDR_KEY);
    assign w_selSw    = (bus.addr == ADDR_SW);
    assign w_selKctrl = (bus.addr == ADDR_KCTRL);
    assign w_selSctrl = (bus.addr == ADDR_SCTRL);

`ifdef MMIO_TIMER_EN
    logic w_selTcnt;
    assign w_selTcnt = (bus.addr == ADDR_TCNT);
    assign bus.hit   = w_selHex | w_selLedr | w_selLedg | w_selKey | w_selSw |
                       w_selKctrl | w_selSctrl | w_selTcnt;
`else
    assign bus.hit   = w_selHex | w_selLedr | w_selLedg | w_selKey | w_selSw |
                       w_selKctrl | w_selSctrl;
`endif

    logic w_wrHex, w_wrLedr, w_wrLedg, w_wrKctrl, w_wrSctrl;
    logic w_rdKey, w_rdSw;

    assign w_wrHex   = bus.wr_en & w_selHex;
    assign w_wrLedr  = bus.wr_en & w_selLedr;
    assign w_wrLedg  = bus.wr_en & w_selLedg;
    assign w_wrKctrl = bus.wr_en & w_selKctrl;
    assign w_wrSctrl = bus.wr_en & w_selSctrl;
    assign w_rdKey   = bus.rd_en & w_selKey;
    assign w_rdSw    = bus.rd_en & w_selSw;

    // Only the low bits of wdata land in most registers.
    logic w_unused;
    assign w_unused = ^bus.wdata;

    // -----------------------------------------------------------------------
    // Key input path. r_keyDeb holds the debounced raw level (1 = released),
    // so reset presets it to "all released" and no press fires on release
    // of reset.
    // -----------------------------------------------------------------------
    logic [KEY_BITS-1:0] r_keySync1, r_keySync2, r_keyDeb;
    logic [CNT_W-1:0]    r_keyCnt [KEY_BITS];
    logic [KEY_BITS-1:0] w_keyFlip;
    logic [KEY_BITS-1:0] w_keyPress;

    always_comb begin
        w_keyFlip = '0;
        for (int i = 0; i < KEY_BITS; i++) begin
            w_keyFlip[i] = (r_keySync2[i] != r_keyDeb[i]) && (r_keyCnt[i] == CNT_MAX);
        end
    end

    // A flip towards 0 is a press.
    assign w_keyPress = w_keyFlip & ~r_keySync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_keySync1 <= '1;
            r_keySync2 <= '1;
            r_keyDeb   <= '1;
            for (int i = 0; i < KEY_BITS; i++) begin
                r_keyCnt[i] <= '0;
            end
        end else begin
            r_keySync1 <= key_n;
            r_keySync2 <= r_keySync1;
            r_keyDeb   <= r_keyDeb ^ w_keyFlip;
            for (int i = 0; i < KEY_BITS; i++) begin
                if ((r_keySync2[i] == r_keyDeb[i]) || w_keyFlip[i]) begin
                    r_keyCnt[i] <= '0;
                end else begin
                    r_keyCnt[i] <= r_keyCnt[i] + 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Switch input path, same structure with an idle level of 0.
    // -----------------------------------------------------------------------
    logic [SW_BITS-1:0] r_swSync1, r_swSync2, r_swDeb;
    logic [CNT_W-1:0]   r_swCnt [SW_BITS];
    logic [SW_BITS-1:0] w_swFlip;
    logic               w_swChange;

    always_comb begin
        w_swFlip = '0;
        for (int i = 0; i < SW_BITS; i++) begin
            w_swFlip[i] = (r_swSync2[i] != r_swDeb[i]) && (r_swCnt[i] == CNT_MAX);
        end
    end

    assign w_swChange = |w_swFlip;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_swSync1 <= '0;
            r_swSync2 <= '0;
            r_swDeb   <= '0;
            for (int i = 0; i < SW_BITS; i++) begin
                r_swCnt[i] <= '0;
            end
        end else begin
            r_swSync1 <= sw;
            r_swSync2 <= r_swSync1;
            r_swDeb   <= r_swDeb ^ w_swFlip;
            for (int i = 0; i < SW_BITS; i++) begin
                if ((r_swSync2[i] == r_swDeb[i]) || w_swFlip[i]) begin
                    r_swCnt[i] <= '0;
                end else begin
                    r_swCnt[i] <= r_swCnt[i] + 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sticky status. Clears come from write-1-to-clear and from reading the
    // matching data register; OR-ing the set term last makes set win.
    // -----------------------------------------------------------------------
    logic [KEY_BITS-1:0] r_keyReady;
    logic                r_keyOvr;
    logic                r_swReady;
    logic                r_swOvr;
    logic [KEY_BITS-1:0] w_keyReadyClr;
    logic                w_keyOvrClr, w_keyOvrSet;
    logic                w_swReadyClr, w_swOvrClr, w_swOvrSet;

    assign w_keyReadyClr = ({KEY_BITS{w_wrKctrl}} & bus.wdata[KEY_BITS-1:0]) |
                           {KEY_BITS{w_rdKey}};
    assign w_keyOvrClr   = w_wrKctrl & bus.wdata[KEY_BITS];
    assign w_keyOvrSet   = |(w_keyPress & r_keyReady);

    assign w_swReadyClr  = (w_wrSctrl & bus.wdata[0]) | w_rdSw;
    assign w_swOvrClr    = w_wrSctrl & bus.wdata[1];
    assign w_swOvrSet    = w_swChange & r_swReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_keyReady <= '0;
            r_keyOvr   <= 1'b0;
            r_swReady  <= 1'b0;
            r_swOvr    <= 1'b0;
        end else begin
            r_keyReady <= (r_keyReady & ~w_keyReadyClr) | w_keyPress;
            r_keyOvr   <= (r_keyOvr & ~w_keyOvrClr) | w_keyOvrSet;
            r_swReady  <= (r_swReady & ~w_swReadyClr) | w_swChange;
            r_swOvr    <= (r_swOvr & ~w_swOvrClr) | w_swOvrSet;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    logic [HEX_BITS-1:0]  r_hex;
    logic [LEDR_BITS-1:0] r_ledr;
    logic [LEDG_BITS-1:0] r_ledg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hex  <= '0;
            r_ledr <= '0;
            r_ledg <= '0;
        end else begin
            if (w_wrHex) begin
                r_hex <= bus.wdata[HEX_BITS-1:0];
            end
            if (w_wrLedr) begin
                r_ledr <= bus.wdata[LEDR_BITS-1:0];
            end
            if (w_wrLedg) begin
                r_ledg <= bus.wdata[LEDG_BITS-1:0];
            end
        end
    end

    assign ledr = r_ledr;
    assign ledg = r_ledg;

`ifdef MMIO_TIMER_EN
    // Free-running cycle counter; a write loads wdata and counting resumes
    // from there on the following edge.
    logic [DBITS-1:0] r_tcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if (bus.wr_en && w_selTcnt) begin
            r_tcnt <= bus.wdata;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Read path. Unmapped addresses fall through to zero, so every read
    // strobe still returns a valid (zero) word.
    // -----------------------------------------------------------------------
    logic [DBITS-1:0] w_rdSel;
    logic [DBITS-1:0] r_rdata;
    logic             r_rvalid;

    always_comb begin
        w_rdSel = '0;
        if (w_selHex) begin
            w_rdSel[HEX_BITS-1:0] = r_hex;
        end else if (w_selLedr) begin
            w_rdSel[LEDR_BITS-1:0] = r_ledr;
        end else if (w_selLedg) begin
            w_rdSel[LEDG_BITS-1:0] = r_ledg;
        end else if (w_selKey) begin
            w_rdSel[KEY_BITS-1:0] = ~r_keyDeb;
        end else if (w_selSw) begin
            w_rdSel[SW_BITS-1:0] = r_swDeb;
        end else if (w_selKctrl) begin
            w_rdSel[KEY_BITS:0] = {r_keyOvr, r_keyReady};
        end else if (w_selSctrl) begin
            w_rdSel[1:0] = {r_swOvr, r_swReady};
        end
`ifdef MMIO_TIMER_EN
        else if (w_selTcnt) begin
            w_rdSel = r_tcnt;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rdata <= w_rdSel;
            end
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;

    // -----------------------------------------------------------------------
    // 7-segment decode, segments active-low in gfedcba order.
    // -----------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [7*HEX_DIGITS-1:0] w_hexSeg;

    always_comb begin
        w_hexSeg = '0;
        for (int d = 0; d < HEX_DIGITS; d++) begin
            w_hexSeg[7*d +: 7] = seg7(r_hex[4*d +: 4]);
        end
    end

    assign hex = w_hexSeg;

endmodule

// File: doc/mmio_controller.md
Name: mmio_controller

Overview:
- Parametrised memory-mapped I/O controller for the CPU data path.
- Decodes data-memory addresses in the 0xF000_0000 page and owns the HEX, LEDR and LEDG output registers.
- Samples KEY and SW through synchronisers and debouncers, with sticky event/status registers.
- Gives the next-generation core a single registered read/write port in place of ad-hoc IO glue.

Parameters:
- DBITS, 32, data/address width
- KEY_BITS, 4, number of key inputs (raw, active-low)
- SW_BITS, 10, number of switch inputs
- LEDR_BITS, 10, red LED count
- LEDG_BITS, 8, green LED count
- HEX_DIGITS, 4, number of 7-segment digits (4 bits each)
- DEBOUNCE_CYCLES, 100000, consecutive stable samples required to accept a new input value (1..2^20)
- ADDR_HEX / ADDR_LEDR / ADDR_LEDG, 32'hF0000000 / 04 / 08, output register addresses
- ADDR_KEY / ADDR_SW, 32'hF0000010 / 14, debounced data
- ADDR_KCTRL / ADDR_SCTRL, 32'hF0000110 / 114, status registers

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- addr  in  DBITS  byte address from the memory stage
- wr_en  in  1  write strobe
- rd_en  in  1  read strobe
- wdata  in  DBITS  write data
- hit  out  1  combinational: addr equals a mapped register
- rdata  out  DBITS  registered read data
- rvalid  out  1  high one cycle after an accepted read
- key_n  in  KEY_BITS  raw keys, 0 = pressed
- sw  in  SW_BITS  raw switches
- ledr  out  LEDR_BITS  red LEDs
- ledg  out  LEDG_BITS  green LEDs
- hex  out  7*HEX_DIGITS  per-digit 7-seg, active-low segments, digit 0 in bits [6:0]

Behaviour:
- Reset, applied immediately:
  - HEX/LEDR/LEDG registers = 0, so hex shows "0" (7'b1000000) on every digit.
  - rdata = 0, rvalid = 0, all status bits = 0, debounce counters = 0.
  - Synchroniser and debounced state preset to the idle value (keys released, switches 0); no event fires at reset release.
- Input path: two-flop synchroniser per bit, then one debounce counter per bit.
  - The counter increments while the synchronised value differs from the debounced value and clears when they match.
  - On reaching DEBOUNCE_CYCLES the debounced bit updates and the counter clears.
  - Earliest latency from a raw change to a debounced change: 2 + DEBOUNCE_CYCLES cycles.
- KEY data reads as the pressed mask (1 = pressed), zero-extended. SW data reads the debounced switches.
- KCTRL:
  - bits [KEY_BITS-1:0] ready: set on a debounced press (0→1) of that key.
  - bit [KEY_BITS] overrun: set if a press arrives while that key's ready bit is already 1.
- SCTRL:
  - bit0 ready: set on any debounced switch change.
  - bit1 overrun: set on a change while ready = 1.
- Status write rule: write-1-to-clear; bits written with 0 are unchanged.
- Reading ADDR_KEY clears all KCTRL ready bits; reading ADDR_SW clears SCTRL ready. Overrun bits are not cleared by these reads.
- Same-cycle set and clear of a status bit: set wins.
- Writes:
  - HEX stores wdata[4*HEX_DIGITS-1:0]; LEDR and LEDG store their low bits.
  - KEY and SW data registers are read-only; writes to them are ignored.
  - Writes take effect on the next edge and outputs update that edge.
- Reads: rd_en with hit captures the selected register into rdata at the next edge and pulses rvalid for one cycle; rdata holds until the next accepted read.
- HEX, LEDR and LEDG read back their stored values. Status registers read the pre-clear value.
- Unmapped address: hit = 0, writes ignored, rd_en gives rvalid = 1 with rdata = 0.
- rd_en and wr_en together on the same address: rdata returns the old value, and the write commits.
- 7-seg decode is combinational from the HEX register, covering 0-9 and A-F.

Optional Feature:
- Macro: MMIO_TIMER_EN.
- Defined: adds a DBITS-bit free-running cycle counter at ADDR_TCNT = 32'hF0000020.
  - Increments every cycle and wraps from all-ones to 0.
  - A write loads wdata; on the next cycle it counts on from wdata+1.
  - Reset sets it to 0.
- Undefined: ADDR_TCNT is unmapped (hit = 0, reads 0) and no counter logic is built.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset, then write 0x1234 to HEX: hex digits 3..0 = 1,2,3,4 patterns; reading ADDR_HEX gives rvalid next cycle with rdata = 0x00001234.
- Hold key_n = 4'b1110 for 10 cycles: KEY reads 0x1 and KCTRL reads 0x1. A second read of KCTRL after reading KEY returns 0x0.
- Glitch key_n[1] low for 3 cycles, then high: no change to KEY or KCTRL.
- Press key0, release, press again without any read: KCTRL = 0x11 (ready + overrun). Write 0x10: KCTRL = 0x01.
- Toggle sw from 0 to 0x2A5: after ≥6 cycles SW reads 0x2A5 and SCTRL = 0x1. Write 0x1 to SCTRL in the same cycle as another debounced change: ready stays 1 (set wins).
- Write 0xFFFFFFFE to TCNT with MMIO_TIMER_EN, read 2 cycles later: rdata = 0x00000000 (wrap). Without the macro: hit = 0 and rdata = 0.
